// File: rtl/int_div_iter.sv
// int_div_iter: iterative restoring integer divider, one quotient bit per cycle.
// Handles unsigned and signed (two's-complement) division with a fixed
// latency of NBITS cycles in CALC, plus divide-by-zero and overflow cases.
module int_div_iter #(
    parameter int unsigned NBITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [2*NBITS:0]     req_msg,
    output logic                 resp_val,
    input  logic                 resp_rdy,
    output logic [2*NBITS-1:0]   resp_msg
);

    localparam int unsigned CW = $clog2(NBITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              req_rdy_q;
    logic              resp_val_q;

    logic [NBITS-1:0]  a_mag_q;
    logic [NBITS-1:0]  b_mag_q;
    logic              sign_a_q;
    logic              sign_b_q;
    logic              func_q;
    logic              dz_q;
    logic [NBITS:0]    rem_q;
    logic [NBITS-1:0]  dvd_q;
    logic [NBITS-1:0]  q_res_q;
    logic [NBITS-1:0]  r_res_q;

    logic              req_go;
    logic              resp_go;
    logic              last_step;

    logic              req_func;
    logic [NBITS-1:0]  req_a;
    logic [NBITS-1:0]  req_b;
    logic [NBITS-1:0]  a_abs;
    logic [NBITS-1:0]  b_abs;

    logic [NBITS+1:0]  rem_sh;
    logic [NBITS+1:0]  diff;
    logic [NBITS:0]    rem_d;
    logic [NBITS-1:0]  dvd_d;
    logic [NBITS-1:0]  q_res_d;
    logic [NBITS-1:0]  r_res_d;

    assign req_rdy   = req_rdy_q;
    assign resp_val  = resp_val_q;
    assign resp_msg  = {q_res_q, r_res_q};

    assign req_go    = req_val & req_rdy_q;
    assign resp_go   = resp_val_q & resp_rdy;
    assign last_step = (state_q == CALC) && (cnt_q == CW'(NBITS - 1));

    // Split the request and take operand magnitudes (0x80..0 stays as unsigned 0x80..0)
    always_comb begin
        req_func = req_msg[2*NBITS];
        req_a    = req_msg[2*NBITS-1:NBITS];
        req_b    = req_msg[NBITS-1:0];
        a_abs    = (req_func & req_a[NBITS-1]) ? -req_a : req_a;
        b_abs    = (req_func & req_b[NBITS-1]) ? -req_b : req_b;
    end

    // One restoring step: shift {rem, dividend}, trial-subtract |b|, restore on borrow
    always_comb begin
        rem_sh = {rem_q, dvd_q[NBITS-1]};
        diff   = rem_sh - {2'b00, b_mag_q};
        if (diff[NBITS+1]) begin
            rem_d = rem_sh[NBITS:0];
            dvd_d = {dvd_q[NBITS-2:0], 1'b0};
        end else begin
            rem_d = diff[NBITS:0];
            dvd_d = {dvd_q[NBITS-2:0], 1'b1};
        end
    end

    // Sign fix-up of the final step; most-negative / -1 falls out naturally as 0x80..0 r=0
    always_comb begin
        q_res_d = dvd_d;
        r_res_d = rem_d[NBITS-1:0];
        if (dz_q) begin
            q_res_d = '1;
            r_res_d = (func_q & sign_a_q) ? -a_mag_q : a_mag_q;
        end else if (func_q) begin
            if (sign_a_q ^ sign_b_q) begin
                q_res_d = -dvd_d;
            end
            if (sign_a_q) begin
                r_res_d = -rem_d[NBITS-1:0];
            end
        end
    end

    // Control FSM with step counter and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_rdy_q  <= 1'b1;
            resp_val_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_go) begin
                        state_q   <= CALC;
                        cnt_q     <= '0;
                        req_rdy_q <= 1'b0;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step) begin
                        state_q    <= DONE;
                        resp_val_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (resp_go) begin
                        state_q    <= IDLE;
                        req_rdy_q  <= 1'b1;
                        resp_val_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    cnt_q      <= '0;
                    req_rdy_q  <= 1'b1;
                    resp_val_q <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: capture operands on accept, iterate in CALC, latch result on last step
    always_ff @(posedge clk) begin
        if (reset) begin
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            func_q   <= 1'b0;
            dz_q     <= 1'b0;
            rem_q    <= '0;
            dvd_q    <= '0;
            q_res_q  <= '0;
            r_res_q  <= '0;
        end else if (req_go) begin
            a_mag_q  <= a_abs;
            b_mag_q  <= b_abs;
            sign_a_q <= req_a[NBITS-1];
            sign_b_q <= req_b[NBITS-1];
            func_q   <= req_func;
            dz_q     <= (req_b == '0);
            rem_q    <= '0;
            dvd_q    <= a_abs;
        end else if (state_q == CALC) begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            if (last_step) begin
                q_res_q <= q_res_d;
                r_res_q <= r_res_d;
            end
        end
    end

endmodule

// File: tb/tb_int_div_iter.sv
// Directed self-checking bench for int_div_iter at NBITS=32.
module tb_int_div_iter;

    logic        clk;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [64:0] req_msg;
    logic        resp_val;
    logic        resp_rdy;
    logic [63:0] resp_msg;

    int n_checks = 0;
    int n_pass   = 0;

    int_div_iter #(.NBITS(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_msg  (req_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request with resp_rdy=1; cyc is the cycle index (T+cyc) where resp_val is first seen
    task automatic run_op(input logic f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r, output int cyc);
        resp_rdy = 1'b1;
        req_val  = 1'b1;
        req_msg  = {f, a, b};
        @(posedge clk); #1;
        req_val  = 1'b0;
        cyc = 1;
        while (resp_val !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        q = resp_msg[63:32];
        r = resp_msg[31:0];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        req_val  = 1'b0;
        resp_rdy = 1'b0;
        req_msg  = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (req_rdy !== 1'b1) $display("FAIL rst_req_rdy: got %b want 1", req_rdy); else n_pass++;
        n_checks++; if (resp_val !== 1'b0) $display("FAIL rst_resp_val: got %b want 0", resp_val); else n_pass++;
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (req_rdy !== 1'b1) $display("FAIL post_rst_req_rdy: got %b want 1", req_rdy); else n_pass++;
        n_checks++; if (resp_val !== 1'b0) $display("FAIL post_rst_resp_val: got %b want 0", resp_val); else n_pass++;
    endtask

    task automatic test_unsigned();
        logic [31:0] q, r;
        int cyc;
        run_op(1'b0, 32'd100, 32'd7, q, r, cyc);
        n_checks++; if (q !== 32'd14) $display("FAIL unsigned_q: got %h want %h", q, 32'd14); else n_pass++;
        n_checks++; if (r !== 32'd2) $display("FAIL unsigned_r: got %h want %h", r, 32'd2); else n_pass++;
        n_checks++; if (cyc != 33) $display("FAIL unsigned_latency: got %0d want 33", cyc); else n_pass++;
    endtask

    task automatic test_signed();
        logic [31:0] q, r;
        int cyc;
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, q, r, cyc);
        n_checks++; if (q !== 32'hFFFF_FFFD) $display("FAIL signed_neg_a_q: got %h want fffffffd", q); else n_pass++;
        n_checks++; if (r !== 32'hFFFF_FFFF) $display("FAIL signed_neg_a_r: got %h want ffffffff", r); else n_pass++;
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, q, r, cyc);
        n_checks++; if (q !== 32'hFFFF_FFFD) $display("FAIL signed_neg_b_q: got %h want fffffffd", q); else n_pass++;
        n_checks++; if (r !== 32'd1) $display("FAIL signed_neg_b_r: got %h want 00000001", r); else n_pass++;
        n_checks++; if (cyc != 33) $display("FAIL signed_latency: got %0d want 33", cyc); else n_pass++;
    endtask

    task automatic test_div_zero();
        logic [31:0] q, r;
        int cyc;
        run_op(1'b0, 32'd5, 32'd0, q, r, cyc);
        n_checks++; if (q !== 32'hFFFF_FFFF) $display("FAIL dz_unsigned_q: got %h want ffffffff", q); else n_pass++;
        n_checks++; if (r !== 32'd5) $display("FAIL dz_unsigned_r: got %h want 00000005", r); else n_pass++;
        run_op(1'b1, 32'hFFFF_FFFB, 32'd0, q, r, cyc);
        n_checks++; if (q !== 32'hFFFF_FFFF) $display("FAIL dz_signed_q: got %h want ffffffff", q); else n_pass++;
        n_checks++; if (r !== 32'hFFFF_FFFB) $display("FAIL dz_signed_r: got %h want fffffffb", r); else n_pass++;
        n_checks++; if (cyc != 33) $display("FAIL dz_latency: got %0d want 33", cyc); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] q, r;
        int cyc;
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r, cyc);
        n_checks++; if (q !== 32'h8000_0000) $display("FAIL ovf_q: got %h want 80000000", q); else n_pass++;
        n_checks++; if (r !== 32'd0) $display("FAIL ovf_r: got %h want 00000000", r); else n_pass++;
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, q, r, cyc);
        n_checks++; if (q !== 32'hFFFF_FFFF) $display("FAIL umax_q: got %h want ffffffff", q); else n_pass++;
        n_checks++; if (r !== 32'd0) $display("FAIL umax_r: got %h want 00000000", r); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bad_stall;
        resp_rdy = 1'b0;
        req_val  = 1'b1;
        req_msg  = {1'b0, 32'd1234, 32'd10};
        @(posedge clk); #1;
        // keep req_val high with a different request; it must be ignored until IDLE
        req_msg  = {1'b0, 32'd50, 32'd5};
        cyc = 1;
        while (resp_val !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++; if (cyc != 33) $display("FAIL bp_latency: got %0d want 33", cyc); else n_pass++;
        n_checks++; if (resp_msg !== {32'd123, 32'd4}) $display("FAIL bp_first_msg: got %h want %h", resp_msg, {32'd123, 32'd4}); else n_pass++;
        bad_stall = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (resp_val !== 1'b1 || req_rdy !== 1'b0 || resp_msg !== {32'd123, 32'd4}) bad_stall++;
        end
        n_checks++; if (bad_stall != 0) $display("FAIL bp_stall_stable: got %0d bad cycles want 0", bad_stall); else n_pass++;
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (req_rdy !== 1'b1) $display("FAIL bp_after_go_req_rdy: got %b want 1", req_rdy); else n_pass++;
        n_checks++; if (resp_val !== 1'b0) $display("FAIL bp_after_go_resp_val: got %b want 0", resp_val); else n_pass++;
        // held request is accepted on this edge
        @(posedge clk); #1;
        req_val = 1'b0;
        cyc = 1;
        while (resp_val !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++; if (resp_msg !== {32'd10, 32'd0}) $display("FAIL bp_second_msg: got %h want %h", resp_msg, {32'd10, 32'd0}); else n_pass++;
        n_checks++; if (cyc != 33) $display("FAIL bp_second_latency: got %0d want 33", cyc); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] q, r;
        int cyc;
        int spurious;
        resp_rdy = 1'b1;
        req_val  = 1'b1;
        req_msg  = {1'b0, 32'd999, 32'd3};
        @(posedge clk); #1;
        req_val  = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++; if (req_rdy !== 1'b1) $display("FAIL midrst_req_rdy: got %b want 1", req_rdy); else n_pass++;
        n_checks++; if (resp_val !== 1'b0) $display("FAIL midrst_resp_val: got %b want 0", resp_val); else n_pass++;
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (resp_val !== 1'b0) spurious++;
        end
        n_checks++; if (spurious != 0) $display("FAIL midrst_no_resp: got %0d resp cycles want 0", spurious); else n_pass++;
        run_op(1'b0, 32'd1000, 32'd10, q, r, cyc);
        n_checks++; if (q !== 32'd100) $display("FAIL midrst_next_q: got %h want 00000064", q); else n_pass++;
        n_checks++; if (r !== 32'd0) $display("FAIL midrst_next_r: got %h want 00000000", r); else n_pass++;
        n_checks++; if (cyc != 33) $display("FAIL midrst_next_latency: got %0d want 33", cyc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
